led_shift_latch: RTL and testbench

Parametrised serial-to-parallel LED data receiver: shifts a serial bit stream into a WIDTH-bit register and counts bits per frame. On each completed frame it transfers the shifted word into a latched output register that drives the LED pins directly, so LEDs never show partial frames. It sits between the host serial interface and the LED driver outputs. It supersedes the plain shift register: configurable bit order, frame counting, a resync input, and an optional daisy-chain output.

---
 rtl/led_shift_latch.sv | 110 +++++++++++
 tb/tb_led_shift_latch.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_shift_latch.sv
// led_shift_latch: serial-to-parallel LED data receiver.
//
// Shifts a serial bit stream into a WIDTH-bit register and counts the bits in
// each frame. When a frame completes, the new word is copied into the latched
// LED register, so the LED pins never show a partial frame.
//
// Parameters:
//   WIDTH     - bits per frame / LED channels (>= 2)
//   MSB_FIRST - 0: first received bit ends up in bit 0
//               1: first received bit ends up in bit WIDTH-1
//
// Optional feature macro: LED_SHIFT_LATCH_DAISY_EN
//   defined   - o_sout carries the bit discarded by the shift register
//               (daisy-chain output)
//   undefined - o_sout is tied to 0
//
// Ports:
//   i_clk        - clock; all state changes on its rising edge
//   i_reset      - asynchronous active-high reset
//   i_data       - serial data bit
//   i_en         - active-low shift enable
//   i_sync       - active-high frame resync; clears the bit counter
//   o_shift      - live shift register contents
//   o_leds       - latched frame, updated only when a frame completes
//   o_frame_done - one-cycle pulse after the edge that latched a frame
//   o_busy       - a frame is partially received
//   o_sout       - daisy-chain serial output

module led_shift_latch #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned MSB_FIRST = 0
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_data,
    input  logic             i_en,
    input  logic             i_sync,
    output logic [WIDTH-1:0] o_shift,
    output logic [WIDTH-1:0] o_leds,
    output logic             o_frame_done,
    output logic             o_busy,
    output logic             o_sout
);

    localparam int unsigned CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    if (WIDTH < 2) begin : g_width_check
        $error("led_shift_latch: WIDTH must be at least 2");
    end

    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] r_leds;
    logic [CW-1:0]    r_cnt;
    logic             r_frame_done;
    logic [WIDTH-1:0] w_shift_next;

    // The new bit enters at the end opposite to where the first bit of the
    // frame has to end up.
    if (MSB_FIRST != 0) begin : g_msb_first
        assign w_shift_next = {r_shift[WIDTH-2:0], i_data};
    end else begin : g_lsb_first
        assign w_shift_next = {i_data, r_shift[WIDTH-1:1]};
    end

    // Priority: reset > sync > shift > hold.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_shift      <= '0;
            r_leds       <= '0;
            r_cnt        <= '0;
            r_frame_done <= 1'b0;
        end else if (i_sync) begin
            // Resync consumes no bit, even with en asserted.
            r_cnt        <= '0;
            r_frame_done <= 1'b0;
        end else if (!i_en) begin
            r_shift <= w_shift_next;
            if (r_cnt == LAST_BIT) begin
                // Latch the value including the bit sampled on this edge.
                r_leds       <= w_shift_next;
                r_cnt        <= '0;
                r_frame_done <= 1'b1;
            end else begin
                r_cnt        <= r_cnt + CW'(1);
                r_frame_done <= 1'b0;
            end
        end else begin
            r_frame_done <= 1'b0;
        end
    end

    assign o_shift      = r_shift;
    assign o_leds       = r_leds;
    assign o_frame_done = r_frame_done;
    assign o_busy       = (r_cnt != '0);

`ifdef LED_SHIFT_LATCH_DAISY_EN
    // The bit that the next shift pushes out, so a downstream stage on the
    // same clock and enable picks up exactly what this stage discards.
    if (MSB_FIRST != 0) begin : g_sout_msb
        assign o_sout = r_shift[WIDTH-1];
    end else begin : g_sout_lsb
        assign o_sout = r_shift[0];
    end
`else
    assign o_sout = 1'b0;
`endif

endmodule

// File: tb/tb_led_shift_latch.sv
// Bench for led_shift_latch: four instances share one stimulus.
//   0: WIDTH=8, MSB_FIRST=0      1: WIDTH=8, MSB_FIRST=1
//   2: chain upstream (MSB_FIRST=0), fed from the bench
//   3: chain downstream (MSB_FIRST=0), fed from instance 2's sout
// A model built on received-bit histories predicts every output each cycle;
// directed literal checks pin the model against hand-computed values.

module tb_led_shift_latch;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic data = 1'b0;
    logic en = 1'b1;
    logic sync = 1'b0;

    logic [7:0] sh0, sh1, sh2, sh3;
    logic [7:0] ld0, ld1, ld2, ld3;
    logic       dn0, dn1, dn2, dn3;
    logic       bz0, bz1, bz2, bz3;
    logic       so0, so1, so2, so3;

    always #5 clk = ~clk;

    led_shift_latch #(.WIDTH(8), .MSB_FIRST(0)) u_lsb (
        .i_clk(clk), .i_reset(reset), .i_data(data), .i_en(en), .i_sync(sync),
        .o_shift(sh0), .o_leds(ld0), .o_frame_done(dn0), .o_busy(bz0), .o_sout(so0)
    );
    led_shift_latch #(.WIDTH(8), .MSB_FIRST(1)) u_msb (
        .i_clk(clk), .i_reset(reset), .i_data(data), .i_en(en), .i_sync(sync),
        .o_shift(sh1), .o_leds(ld1), .o_frame_done(dn1), .o_busy(bz1), .o_sout(so1)
    );
    led_shift_latch #(.WIDTH(8), .MSB_FIRST(0)) u_up (
        .i_clk(clk), .i_reset(reset), .i_data(data), .i_en(en), .i_sync(sync),
        .o_shift(sh2), .o_leds(ld2), .o_frame_done(dn2), .o_busy(bz2), .o_sout(so2)
    );
    led_shift_latch #(.WIDTH(8), .MSB_FIRST(0)) u_down (
        .i_clk(clk), .i_reset(reset), .i_data(so2), .i_en(en), .i_sync(sync),
        .o_shift(sh3), .o_leds(ld3), .o_frame_done(dn3), .o_busy(bz3), .o_sout(so3)
    );

    int n_checks = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    bit         hist0[$], hist1[$], hist2[$], hist3[$];
    int         pos [4];
    logic [7:0] m_leds [4];
    bit         m_done [4];
    int         cyc = 0;
    bit         chk_on = 0;
    int         done_q[$];

    function automatic bit msb_of(input int k);
        return (k == 1);
    endfunction

    function automatic bit hist_bit(input int k, input int idx);
        case (k)
            0: return hist0[idx];
            1: return hist1[idx];
            2: return hist2[idx];
            default: return hist3[idx];
        endcase
    endfunction

    function automatic int hist_len(input int k);
        case (k)
            0: return hist0.size();
            1: return hist1.size();
            2: return hist2.size();
            default: return hist3.size();
        endcase
    endfunction

    // Live register = the last 8 received bits, newest at the entry end.
    function automatic logic [7:0] m_shift(input int k);
        logic [7:0] w;
        int n;
        w = '0;
        n = hist_len(k);
        for (int j = 0; j < 8 && j < n; j++) begin
            if (msb_of(k)) w[j] = hist_bit(k, n - 1 - j);
            else           w[7 - j] = hist_bit(k, n - 1 - j);
        end
        return w;
    endfunction

    function automatic bit m_sout(input int k);
`ifdef LED_SHIFT_LATCH_DAISY_EN
        logic [7:0] s;
        s = m_shift(k);
        return msb_of(k) ? s[7] : s[0];
`else
        return (k < 0);
`endif
    endfunction

    task automatic push_bit(input int k, input bit b);
        case (k)
            0: hist0.push_back(b);
            1: hist1.push_back(b);
            2: hist2.push_back(b);
            default: hist3.push_back(b);
        endcase
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            hist0.delete(); hist1.delete(); hist2.delete(); hist3.delete();
            for (int k = 0; k < 4; k++) begin
                pos[k] = 0; m_leds[k] = '0; m_done[k] = 0;
            end
        end else begin
            bit din [4];
            cyc++;
            din[0] = data; din[1] = data; din[2] = data; din[3] = m_sout(2);
            for (int k = 0; k < 4; k++) begin
                if (sync) begin
                    pos[k] = 0; m_done[k] = 0;
                end else if (!en) begin
                    push_bit(k, din[k]);
                    pos[k]++;
                    if (pos[k] == 8) begin
                        pos[k] = 0; m_leds[k] = m_shift(k); m_done[k] = 1;
                    end else begin
                        m_done[k] = 0;
                    end
                end else begin
                    m_done[k] = 0;
                end
            end
        end
    end

    task automatic cmp_inst(input int k, input logic [7:0] s, input logic [7:0] l,
                            input logic d, input logic b, input logic o);
        chk($sformatf("i%0d_shift c%0d", k, cyc), {24'd0, s}, {24'd0, m_shift(k)});
        chk($sformatf("i%0d_leds c%0d", k, cyc), {24'd0, l}, {24'd0, m_leds[k]});
        chk($sformatf("i%0d_done c%0d", k, cyc), {31'd0, d}, {31'd0, m_done[k]});
        chk($sformatf("i%0d_busy c%0d", k, cyc), {31'd0, b}, {31'd0, pos[k] != 0});
        chk($sformatf("i%0d_sout c%0d", k, cyc), {31'd0, o}, {31'd0, m_sout(k)});
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            cmp_inst(0, sh0, ld0, dn0, bz0, so0);
            cmp_inst(1, sh1, ld1, dn1, bz1, so1);
            cmp_inst(2, sh2, ld2, dn2, bz2, so2);
            cmp_inst(3, sh3, ld3, dn3, bz3, so3);
            if (dn0) done_q.push_back(cyc);
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input bit d, input bit e, input bit s);
        @(negedge clk);
        data = d; en = e; sync = s;
        @(posedge clk);
        #1;
    endtask

    // Reset asserted between edges; outputs must clear before the next edge.
    task automatic do_reset();
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("rst_shift", {24'd0, sh0}, 32'd0);
        chk("rst_leds", {24'd0, ld0}, 32'd0);
        chk("rst_done", {31'd0, dn0}, 32'd0);
        chk("rst_busy", {31'd0, bz0}, 32'd0);
        chk("rst_sout", {31'd0, so1}, 32'd0);
        chk("rst_leds_msb", {24'd0, ld1}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0; en = 1'b1; sync = 1'b0; data = 1'b0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : driver
        logic [7:0] seq;
        logic [7:0] w;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk_on = 1'b1;

        // Frame 1,0,1,1,0,0,0,1.
        seq = 8'b1000_1101;  // seq[i] is the i-th bit sent
        for (int i = 0; i < 8; i++) begin
            step(seq[i], 1'b0, 1'b0);
            if (i < 7) begin
                chk("f1_busy", {31'd0, bz0}, 32'd1);
                chk("f1_leds_hold", {24'd0, ld1}, 32'd0);
                chk("f1_nodone", {31'd0, dn0}, 32'd0);
            end
        end
        chk("f1_leds_lsb", {24'd0, ld0}, 32'h8D);
        chk("f1_leds_msb", {24'd0, ld1}, 32'hB1);
        chk("f1_done", {31'd0, dn0}, 32'd1);
        chk("f1_busy_end", {31'd0, bz0}, 32'd0);
        step(1'b0, 1'b1, 1'b0);
        chk("f1_done_pulse", {31'd0, dn0}, 32'd0);
        chk("f1_leds_held", {24'd0, ld0}, 32'h8D);

        // Mid-frame reset, then sync with en low, then eight ones.
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        do_reset();
        for (int i = 0; i < 3; i++) step(i[0], 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        chk("sync_busy", {31'd0, bz0}, 32'd0);
        chk("sync_shift", {24'd0, sh0}, 32'h40);
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b0, 1'b0);
            if (i < 7) chk("sync_nodone", {31'd0, dn0}, 32'd0);
        end
        chk("sync_leds", {24'd0, ld0}, 32'hFF);
        chk("sync_done", {31'd0, dn0}, 32'd1);

        // Back-to-back frames 0F then F0 (LSB first on instance 0).
        do_reset();
        done_q.delete();
        w = 8'h0F;
        for (int i = 0; i < 8; i++) step(w[i], 1'b0, 1'b0);
        chk("b2b_leds1", {24'd0, ld0}, 32'h0F);
        w = 8'hF0;
        for (int i = 0; i < 8; i++) step(w[i], 1'b0, 1'b0);
        chk("b2b_leds2", {24'd0, ld0}, 32'hF0);
        step(1'b0, 1'b1, 1'b0);
        chk("b2b_pulses", done_q.size(), 32'd2);
        if (done_q.size() == 2) chk("b2b_spacing", done_q[1] - done_q[0], 32'd8);

        // Enable gaps between every bit.
        do_reset();
        w = 8'h5A;
        for (int i = 0; i < 8; i++) begin
            step(w[i], 1'b0, 1'b0);
            step(1'b0, 1'b1, 1'b0);
            step(1'b1, 1'b1, 1'b0);
        end
        chk("gap_leds", {24'd0, ld0}, 32'h5A);

        // Daisy chain: 16 bits, A5 then 3C, LSB first.
        do_reset();
        w = 8'hA5;
        for (int i = 0; i < 8; i++) step(w[i], 1'b0, 1'b0);
        w = 8'h3C;
        for (int i = 0; i < 8; i++) step(w[i], 1'b0, 1'b0);
        chk("chain_up_leds", {24'd0, ld2}, 32'h3C);
`ifdef LED_SHIFT_LATCH_DAISY_EN
        chk("chain_down_leds", {24'd0, ld3}, 32'hA5);
`else
        chk("chain_down_leds", {24'd0, ld3}, 32'h00);
        chk("chain_sout", {31'd0, so2}, 32'd0);
`endif
        step(1'b0, 1'b1, 1'b0);

        chk_on = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
